// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder
//   Memory-side responder for the page-table walker's PTE read port. Each
//   new walker address becomes one read on a valid/ready memory bus. The
//   returned 64-bit PTE is held on rdata, and mmu_stall holds the walker
//   until that data matches the address it is presenting.
//
//   Optional feature: define PTW_PTE_CACHE_EN to add a small direct-mapped
//   PTE cache (CACHE_ENTRIES deep) in front of the bus. Without it, flush is
//   ignored and every new address goes to the bus.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   addr, ren                    walker request (ren held for the whole walk)
//   rdata, mmu_stall             PTE data back to the walker / not-valid flag
//   flush                        satp write or sfence: drop cached PTEs
//   mem_req_valid/ready/addr     bus read request channel
//   mem_resp_valid/data/err      bus read response (one beat per request)
//   rd_count                     saturating count of accepted bus reads
module ptw_mem_responder #(
  parameter int CACHE_ENTRIES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      addr,
  input  logic             ren,
  output logic [63:0]      rdata,
  output logic             mmu_stall,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [63:0]      mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_data,
  input  logic             mem_resp_err,
  output logic [CNT_W-1:0] rd_count
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [63:0]        lat_addr_q, lat_addr_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               req_vld_q, req_vld_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_inc, start, lookup;
  logic               addr_hit, keep;
  logic [63:0]        new_baddr;
  logic               cache_hit;
  logic [63:0]        cache_data;

  // The PTE index is a doubleword index; addr[11:9] are not part of it.
  // The shifted index fits in 12 bits, so the add reduces to a concatenation.
  assign new_baddr = {addr[63:12], addr[8:0], 3'b000};
  assign addr_hit  = (addr == lat_addr_q);
  // The current transaction is still wanted by the walker.
  assign keep      = ren & addr_hit;

  assign mmu_stall     = ren & ~(rst & (state_q == S_DONE) & addr_hit);
  assign rdata         = rdata_q;
  assign mem_req_valid = req_vld_q;
  assign mem_req_addr  = req_addr_q;
  assign rd_count      = cnt_q;

`ifdef PTW_PTE_CACHE_EN
  localparam int IW = $clog2(CACHE_ENTRIES);

  logic [CACHE_ENTRIES-1:0] cvld_q;
  logic [60:0]              ctag_q [CACHE_ENTRIES];
  logic [63:0]              cdat_q [CACHE_ENTRIES];
  logic [IW-1:0]            lk_idx, fill_idx;
  logic                     resp_take, fill_en;

  assign lk_idx     = new_baddr[3 +: IW];
  assign fill_idx   = req_addr_q[3 +: IW];
  // No hits in the flush cycle: the entry is about to be invalidated.
  assign cache_hit  = cvld_q[lk_idx] & (ctag_q[lk_idx] == new_baddr[63:3]) & ~flush;
  assign cache_data = cdat_q[lk_idx];
  // Any consumed response (kept or drained) carries valid data for
  // req_addr_q, so both may fill.
  assign resp_take  = mem_resp_valid &
                      ((state_q == S_WAIT) | ((state_q == S_DRAIN) & ~req_vld_q));
  assign fill_en    = resp_take & ~mem_resp_err & ~flush;

  always_ff @(posedge clk) begin
    if (!rst)         cvld_q <= '0;
    else if (flush)   cvld_q <= '0;
    else if (fill_en) cvld_q[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      ctag_q[fill_idx] <= req_addr_q[63:3];
      cdat_q[fill_idx] <= mem_resp_data;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign cache_hit    = 1'b0;
  assign cache_data   = '0;
`endif

  always_comb begin
    state_d    = state_q;
    lat_addr_d = lat_addr_q;
    rdata_d    = rdata_q;
    req_vld_d  = req_vld_q;
    req_addr_d = req_addr_q;
    cnt_inc    = 1'b0;
    start      = 1'b0;
    lookup     = 1'b0;
    case (state_q)
      S_IDLE: if (ren) begin start = 1'b1; lookup = 1'b1; end
      S_REQ: begin
        // A presented request is never withdrawn; an abort only changes
        // where we go once it has been accepted.
        if (mem_req_ready) begin
          req_vld_d = 1'b0;
          cnt_inc   = 1'b1;
          state_d   = keep ? S_WAIT : S_DRAIN;
        end else if (!keep) begin
          state_d = S_DRAIN;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          if (keep) begin
            // A zero PTE has V=0, so an error aborts the walk.
            rdata_d = mem_resp_err ? 64'h0 : mem_resp_data;
            state_d = S_DONE;
          end else if (ren) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (!keep) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!ren)           state_d = S_IDLE;
        else if (!addr_hit) begin start = 1'b1; lookup = 1'b1; end
      end
      S_DRAIN: begin
        // Aborted from REQ: the request may still be waiting for ready.
        if (req_vld_q) begin
          if (mem_req_ready) begin
            req_vld_d = 1'b0;
            cnt_inc   = 1'b1;
          end
        end else if (mem_resp_valid) begin
          if (ren) start = 1'b1;
          else     state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      lat_addr_d = addr;
      req_addr_d = new_baddr;
      if (lookup && cache_hit) begin
        rdata_d = cache_data;
        state_d = S_DONE;
      end else begin
        req_vld_d = 1'b1;
        state_d   = S_REQ;
      end
    end

    cnt_d = (cnt_inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lat_addr_q <= '0;
      rdata_q    <= '0;
      req_vld_q  <= 1'b0;
      req_addr_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      lat_addr_q <= lat_addr_d;
      rdata_q    <= rdata_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
